shift_reg_n: RTL
================

Name: shift_reg_n

Overview:
- Parametrised successor to the fixed 3-bit load register.
- Holds a WIDTH-bit word with synchronous clear, parallel load, and single-cycle shifts in four modes (logical/serial-in, arithmetic, rotate, hold) in either direction.
- Adds a multi-cycle "shift by Count" operation with Busy/Done handshake, so a multiplier or divider datapath can issue an N-bit shift with one request.
- Sits in the datapath as the accumulator/operand register, driven by the control FSM.

Parameters:
- WIDTH, 8, data word width in bits; legal range is 2 or more.
- CNT_W, 4, width of the shift-count field; must satisfy 2**CNT_W > WIDTH.
- RESET_VAL, 0, value loaded into Data_Out on Reset and Clear (WIDTH bits).

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Clear  in  1  synchronous clear to RESET_VAL; aborts any shift in progress.
- Load  in  1  parallel load of D.
- D  in  WIDTH  parallel load data.
- Shift_En  in  1  perform one shift this edge.
- Start  in  1  begin a multi-cycle shift of Count positions.
- Count  in  CNT_W  number of shifts for Start.
- Dir  in  1  0 = shift right (toward bit 0), 1 = shift left.
- Mode  in  2  00 logical with Shift_In fill; 01 arithmetic; 10 rotate; 11 hold.
- Shift_In  in  1  serial fill bit, used in Mode 00 only.
- Data_Out  out  WIDTH  register contents.
- Shift_Out  out  1  combinational; Data_Out[0] if Dir=0, else Data_Out[WIDTH-1]. This is the bit that leaves on the next shift.
- Busy  out  1  multi-cycle shift in progress (registered).
- Done  out  1  one-cycle pulse when a Start operation completes (registered).

Behaviour:
- Reset (asynchronous, active-high; clock Clk):
  - Data_Out=RESET_VAL, Busy=0, Done=0, internal counter=0, FSM=IDLE.
  - Takes effect immediately, including mid-operation.
- Shift rules:
  - Mode 00, right: {Shift_In, Data_Out[WIDTH-1:1]}. Left: {Data_Out[WIDTH-2:0], Shift_In}.
  - Mode 01, right: {Data_Out[WIDTH-1], Data_Out[WIDTH-1:1]} (sign replicate). Left: {Data_Out[WIDTH-2:0], 1'b0}.
  - Mode 10, right: {Data_Out[0], Data_Out[WIDTH-1:1]}. Left: {Data_Out[WIDTH-2:0], Data_Out[WIDTH-1]}.
  - Mode 11: Data_Out unchanged. In a multi-cycle operation the count still decrements.
- IDLE priority per edge: Clear > Load > Start > Shift_En > hold. Only the highest-priority request acts.
- FSM states: IDLE and SHIFT.
- IDLE with Start=1 (no Clear/Load):
  - Latch Dir and Mode; remaining = Count.
  - If Count=0: stay IDLE, Done=1 for the next cycle, data unchanged.
  - Otherwise go to SHIFT with Busy=1.
- SHIFT:
  - Each edge performs one shift using the latched Dir/Mode and the live Shift_In, then decrements remaining.
  - On the edge that performs the last shift (remaining==1): go to IDLE, Busy=0, Done=1 for exactly one cycle.
- Latency: Start with Count=N>0 sampled at edge E0 → shifts at E1..EN.
  - Busy is high from after E0 through EN.
  - Done is high from EN to EN+1.
- While in SHIFT, Load, Start and Shift_En are ignored; no queuing.
- Clear in SHIFT: Data_Out=RESET_VAL, Busy=0, FSM=IDLE, no Done pulse.
- Done is never asserted together with Busy.
- Count larger than WIDTH is legal; exactly Count shifts are performed.
- Dir and Mode changes during SHIFT have no effect. Shift_In changes are honoured per cycle.

Test Plan:
1. Assert Reset asynchronously between edges while Data_Out=0x5A and Busy=1 → Data_Out=0x00, Busy=0, Done=0 immediately, with no clock edge.
2. WIDTH=8: Load D=0xA5 → 0xA5, Shift_Out=1 (Dir=0). Then Shift_En, Dir=0, Mode=01 → 0xD2. Then Shift_En, Mode=00, Shift_In=1 → 0xE9.
3. Load 0x81, then Start, Count=3, Dir=1, Mode=10 → Data_Out 0x03, 0x06, 0x0C on E1..E3. Busy high for 3 cycles; Done high only in the cycle after E3.
4. Start, Count=0 with Data_Out=0x3C → Busy stays 0, Done=1 for one cycle, Data_Out=0x3C.
5. Start, Count=5, Mode=00, Dir=0, Shift_In=0 from 0xFF; pulse Load D=0x11 at E2 → Load ignored. Assert Clear at E3 → Data_Out=0x00, Busy=0, and no Done pulse follows.
6. Load and Shift_En asserted on the same edge in IDLE, D=0x42 → Data_Out=0x42 with no shift. Clear and Load on the same edge → Data_Out=RESET_VAL.

Source files
------------

// File: rtl/shift_reg_n.sv
// Accumulator/operand register: clear, load, single shifts and counted multi-cycle shifts.
// Latency: single-cycle ops take effect on the next edge; Start with Count=N finishes on edge N.
// Backpressure: while Busy, Load/Start/Shift_En are dropped (not queued); only Clear aborts.
module shift_reg_n #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Shift_En,
    input  logic             Start,
    input  logic [CNT_W-1:0] Count,
    input  logic             Dir,
    input  logic [1:0]       Mode,
    input  logic             Shift_In,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Shift_Out,
    output logic             Busy,
    output logic             Done
);

    // FSM encoding kept as plain constants so legacy control code can compare against them
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [1:0] MODE_LOGIC = 2'b00;
    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [0:0]       state_q,   state_nxt;
    logic [WIDTH-1:0] data_q,    data_nxt;
    logic [CNT_W-1:0] remain_q,  remain_nxt;
    logic             dir_q,     dir_nxt;
    logic [1:0]       mode_q,    mode_nxt;
    logic             busy_q,    busy_nxt;
    logic             done_q,    done_nxt;

    // One shift step; the fill bit is the only thing that differs between modes.
    // Arithmetic left shifts in zero, arithmetic right replicates the sign bit.
    function automatic logic [WIDTH-1:0] shift_word(
        input logic [WIDTH-1:0] cur,
        input logic             dir,
        input logic [1:0]       mode,
        input logic             sin
    );
        logic fill;
        fill = 1'b0;
        case (mode)
            MODE_LOGIC: fill = sin;
            MODE_ARITH: fill = dir ? 1'b0 : cur[WIDTH-1];
            MODE_ROT:   fill = dir ? cur[WIDTH-1] : cur[0];
            default:    fill = 1'b0;
        endcase
        if (mode == 2'b11) begin
            shift_word = cur;
        end else if (dir) begin
            shift_word = {cur[WIDTH-2:0], fill};
        end else begin
            shift_word = {fill, cur[WIDTH-1:1]};
        end
    endfunction

    // Next-state decode: IDLE resolves Clear > Load > Start > Shift_En, SHIFT runs the counter
    always_comb begin
        state_nxt  = state_q;
        data_nxt   = data_q;
        remain_nxt = remain_q;
        dir_nxt    = dir_q;
        mode_nxt   = mode_q;
        busy_nxt   = busy_q;
        done_nxt   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Clear) begin
                    data_nxt = RESET_VAL;
                end else if (Load) begin
                    data_nxt = D;
                end else if (Start) begin
                    // Direction and mode are captured so the controller may move on
                    dir_nxt    = Dir;
                    mode_nxt   = Mode;
                    remain_nxt = Count;
                    if (Count == CNT_ZERO) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = SHIFT;
                        busy_nxt  = 1'b1;
                    end
                end else if (Shift_En) begin
                    data_nxt = shift_word(data_q, Dir, Mode, Shift_In);
                end
            end
            SHIFT: begin
                if (Clear) begin
                    // Abort: no Done, counter parked at zero
                    data_nxt   = RESET_VAL;
                    remain_nxt = CNT_ZERO;
                    state_nxt  = IDLE;
                    busy_nxt   = 1'b0;
                end else begin
                    // Shift_In is sampled live each cycle; Dir/Mode come from the latch
                    data_nxt   = shift_word(data_q, dir_q, mode_q, Shift_In);
                    remain_nxt = remain_q - CNT_ONE;
                    if (remain_q == CNT_ONE) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State registers; Reset is asynchronous and wins mid-operation
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            data_q   <= RESET_VAL;
            remain_q <= CNT_ZERO;
            dir_q    <= 1'b0;
            mode_q   <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            data_q   <= data_nxt;
            remain_q <= remain_nxt;
            dir_q    <= dir_nxt;
            mode_q   <= mode_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    assign Data_Out  = data_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    // The bit that will leave on the next shift, following the live Dir input
    assign Shift_Out = Dir ? data_q[WIDTH-1] : data_q[0];

    // Done marks completion, so it can never overlap an operation still in flight
    a_done_not_busy: assert property (@(posedge Clk) disable iff (Reset) !(busy_q && done_q));

endmodule
